// File: rtl/fft_data_output_pkg.sv
// rtl/fft_data_output_pkg.sv - shared state encoding and {IM,RE} field slices for the FFT output capture
package fft_data_output_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Same slices as the FFT input stage: RE in the low word, IM in the high word.
  localparam int RE_LSB = 0;
  localparam int IM_LSB = 32;
  localparam int WORD_W = 32;

endpackage

// File: rtl/fft_sample_ram.sv
// rtl/fft_sample_ram.sv - sample RAM: one 64-bit beat writes an RE/IM word pair, 32-bit registered read
module fft_sample_ram
  import fft_data_output_pkg::*;
#(
  parameter int NFFT = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [NFFT-1:0]     wr_idx,
  input  logic [63:0]         wr_data,
  input  logic                rd_en,
  input  logic [NFFT:0]       rd_addr,
  output logic [WORD_W-1:0]   rd_data
);

  localparam int DEPTH = 2**NFFT;

  // Even words (RE) and odd words (IM) live in separate banks so each has one write port.
  logic [WORD_W-1:0] re_bank [DEPTH];
  logic [WORD_W-1:0] im_bank [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      re_bank[wr_idx] <= wr_data[RE_LSB +: WORD_W];
      im_bank[wr_idx] <= wr_data[IM_LSB +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_addr[0] ? im_bank[rd_addr[NFFT:1]] : re_bank[rd_addr[NFFT:1]];
    end
  end

endmodule

// File: rtl/fft_data_output.sv
// rtl/fft_data_output.sv - captures one AXIS frame of FFT results into RAM and flags framing errors
module fft_data_output
  import fft_data_output_pkg::*;
#(
  parameter int NFFT               = 3,
  parameter int POINT_SIZE         = 2**NFFT,
  parameter int N_ELEMENTS         = 2*POINT_SIZE,
  parameter int ELEMENTS_ADDR_SIZE = $clog2(N_ELEMENTS)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic                          s_tlast,
  input  logic [63:0]                   s_tdata,
  input  logic                          arm,
  output logic                          capturing,
  output logic                          done,
  output logic                          tlast_err,
  output logic [NFFT:0]                 beat_cnt,
  input  logic [ELEMENTS_ADDR_SIZE-1:0] rAddr,
  input  logic                          rEn,
  output logic [31:0]                   rData
);

  localparam logic [NFFT:0] LAST_IDX = (NFFT+1)'(POINT_SIZE - 1);

  logic [1:0] state;
  logic       beat;
  logic       wr_en;

  assign beat  = s_tvalid && s_tready;
  assign wr_en = beat && (state == ST_CAPTURE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      s_tready  <= 1'b0;
      capturing <= 1'b0;
      done      <= 1'b0;
      tlast_err <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state     <= ST_CAPTURE;
            s_tready  <= 1'b1;
            capturing <= 1'b1;
            done      <= 1'b0;
            tlast_err <= 1'b0;
            beat_cnt  <= '0;
          end
        end
        ST_CAPTURE: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_IDX && !s_tlast) begin
              // Frame too long: keep accepting until the sender's tlast arrives.
              state     <= ST_DRAIN;
              tlast_err <= 1'b1;
            end else if (s_tlast) begin
              state     <= ST_DONE;
              s_tready  <= 1'b0;
              capturing <= 1'b0;
              done      <= 1'b1;
              tlast_err <= (beat_cnt != LAST_IDX);
            end
          end
        end
        default: begin
          if (beat && s_tlast) begin
            state     <= ST_DONE;
            s_tready  <= 1'b0;
            capturing <= 1'b0;
            done      <= 1'b1;
          end
        end
      endcase
    end
  end

  fft_sample_ram #(.NFFT(NFFT)) u_ram (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_idx  (beat_cnt[NFFT-1:0]),
    .wr_data (s_tdata),
    .rd_en   (rEn),
    .rd_addr (rAddr),
    .rd_data (rData)
  );

endmodule

// File: tb/tb_fft_data_output.sv
// tb/tb_fft_data_output.sv - randomized and directed self-checking bench for fft_data_output
module tb_fft_data_output;

  localparam int NFFT = 3;
  localparam int PS   = 8;
  localparam int NE   = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [63:0] s_tdata;
  logic        arm;
  logic        capturing;
  logic        done;
  logic        tlast_err;
  logic [3:0]  beat_cnt;
  logic [3:0]  rAddr;
  logic        rEn;
  logic [31:0] rData;

  int n_vec = 0;
  int n_err = 0;

  // Reference: expected RAM image and frame outcome.
  logic [31:0] ref_ram [NE];
  int          m_mode;   // 0 capturing, 1 draining, 2 finished
  int          m_cnt;
  logic        m_err;

  always #5 clk = ~clk;

  fft_data_output #(.NFFT(NFFT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .s_tdata   (s_tdata),
    .arm       (arm),
    .capturing (capturing),
    .done      (done),
    .tlast_err (tlast_err),
    .beat_cnt  (beat_cnt),
    .rAddr     (rAddr),
    .rEn       (rEn),
    .rData     (rData)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input logic [63:0] d, input logic l);
    if (m_mode == 0) begin
      ref_ram[2*m_cnt]   = d[31:0];
      ref_ram[2*m_cnt+1] = d[63:32];
      m_cnt++;
      if (m_cnt == PS) begin
        if (l) m_mode = 2;
        else begin m_mode = 1; m_err = 1'b1; end
      end else if (l) begin
        m_mode = 2;
        m_err  = 1'b1;
      end
    end else if (m_mode == 1 && l) begin
      m_mode = 2;
    end
  endtask

  // Called on a negedge; returns on the negedge after the beat was accepted.
  task automatic send(input logic [63:0] d, input logic l, input logic a, input int gap);
    int w = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l; arm = a;
    while (!s_tready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) check("tready_timeout", 32'(s_tready), 32'd1);
    if (m_mode == 1) check("drain_tready", 32'(s_tready), 32'd1);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0; arm = 1'b0;
    model_beat(d, l);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    m_mode = 0; m_cnt = 0; m_err = 1'b0;
    check("arm_tready", 32'(s_tready), 32'd1);
    check("arm_capturing", 32'(capturing), 32'd1);
    check("arm_done", 32'(done), 32'd0);
    check("arm_tlast_err", 32'(tlast_err), 32'd0);
    check("arm_beat_cnt", 32'(beat_cnt), 32'd0);
  endtask

  task automatic read_all();
    for (int a = 0; a < NE; a++) begin
      rAddr = 4'(a); rEn = 1'b1;
      @(negedge clk);
      check($sformatf("ram[%0d]", a), rData, ref_ram[a]);
    end
    rEn = 1'b0; rAddr = 4'd0;
    @(negedge clk);
    check("rdata_hold", rData, ref_ram[NE-1]);
  endtask

  // mode: 0 pattern {i+100,i}, 1 constant 0xDEAD, 2 random. gap<0 picks random gaps.
  task automatic run_frame(input int n, input int tl, input int gap, input int mode, input int arm_at);
    logic [63:0] d;
    int g;
    do_arm();
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: d = {32'(i + 100), 32'(i)};
        1: d = {32'hDEAD, 32'hDEAD};
        default: d = {$urandom, $urandom};
      endcase
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      send(d, i == tl, i == arm_at, g);
    end
    check("done", 32'(done), 32'(m_mode == 2));
    check("tlast_err", 32'(tlast_err), 32'(m_err));
    check("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    check("tready_end", 32'(s_tready), 32'(m_mode != 2));
    check("capturing_end", 32'(capturing), 32'(m_mode != 2));
    read_all();
  endtask

  initial begin
    resetn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    arm = 1'b0; rAddr = '0; rEn = 1'b0;
    m_mode = 2; m_cnt = 0; m_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_capturing", 32'(capturing), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tlast_err", 32'(tlast_err), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("rst_rdata", rData, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_tready", 32'(s_tready), 32'd0);

    run_frame(8, 7, 0, 0, -1);     // normal back-to-back
    run_frame(8, 7, 3, 0, -1);     // 3-cycle gaps between beats
    run_frame(8, 7, 0, 1, -1);     // preload 0xDEAD
    run_frame(5, 4, 0, 0, -1);     // early tlast, words 10..15 stay 0xDEAD
    run_frame(11, 10, 0, 2, -1);   // missing tlast, drain 3 beats
    run_frame(8, 7, 0, 2, 2);      // arm during capture is ignored

    // arm in DONE restarts immediately; then reset mid-capture after beat 3
    do_arm();
    for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 1'b0, 1'b0, 0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_mode = 2;
    check("mid_rst_tready", 32'(s_tready), 32'd0);
    check("mid_rst_capturing", 32'(capturing), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_tlast_err", 32'(tlast_err), 32'd0);
    check("mid_rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("mid_rst_rdata", rData, 32'd0);
    @(negedge clk);
    check("post_rst_tready", 32'(s_tready), 32'd0);
    read_all();                    // partial frame kept in RAM
    run_frame(8, 7, 0, 0, -1);

    for (int k = 0; k < 8; k++) begin
      int tl;
      tl = int'($urandom_range(0, 10));
      run_frame(tl + 1, tl, -1, 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_data_output.md
Name: fft_data_output

Overview:
- Capture stage directly downstream of the FFT core.
- Accepts one frame of POINT_SIZE complex results over an AXI4-Stream slave and stores them in an internal RAM as interleaved 32-bit RE/IM words.
- Exposes the RAM through a simple read port for the AXI register front-end.
- Reports frame completion and framing (tlast) errors.

Parameters:
- NFFT, 3, log2 of FFT point count.
- POINT_SIZE, 2**NFFT, complex samples per frame.
- N_ELEMENTS, 2*POINT_SIZE, 32-bit words stored.
- ELEMENTS_ADDR_SIZE, $clog2(N_ELEMENTS), read address width.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- s_tvalid  in  1  AXIS slave valid.
- s_tready  out  1  AXIS slave ready.
- s_tlast  in  1  AXIS last beat of frame.
- s_tdata  in  64  {IM[63:32], RE[31:0]}.
- arm  in  1  single-cycle pulse; starts a capture.
- capturing  out  1  high while in CAPTURE or DRAIN.
- done  out  1  frame captured; held until next arm.
- tlast_err  out  1  framing error on last capture; held until next arm.
- beat_cnt  out  NFFT+1  beats stored in the current/last capture.
- rAddr  in  ELEMENTS_ADDR_SIZE  read word address.
- rEn  in  1  read enable.
- rData  out  32  read data.

Behaviour:
- Reset: clk and resetn are as above; resetn is synchronous and active-low. On reset: state IDLE, s_tready=0, capturing=0, done=0, tlast_err=0, beat_cnt=0, rData=0. RAM contents are not reset.
- Beat definition: a beat occurs when s_tvalid && s_tready.
- States: IDLE, CAPTURE, DRAIN, DONE. All outputs are registered.
- IDLE:
  - s_tready=0.
  - arm=1 -> CAPTURE next cycle; clear done, tlast_err, beat_cnt.
- CAPTURE:
  - s_tready=1 and capturing=1, both from the first cycle in the state (one cycle after arm).
  - Each beat at index i: ram[2i]<=s_tdata[31:0], ram[2i+1]<=s_tdata[63:32], beat_cnt<=i+1.
  - Beat with i==POINT_SIZE-1 and s_tlast=1 -> DONE (normal completion).
  - Beat with i<POINT_SIZE-1 and s_tlast=1 (early tlast) -> DONE with tlast_err=1. Unwritten RAM words keep their old values.
  - Beat with i==POINT_SIZE-1 and s_tlast=0 (missing tlast) -> DRAIN with tlast_err=1.
  - s_tvalid gaps stall the index; there is no timeout.
- DRAIN:
  - s_tready=1; beats are discarded with no RAM write and no beat_cnt change.
  - A beat with s_tlast=1 -> DONE.
- DONE:
  - s_tready=0, capturing=0, done=1.
  - arm=1 -> CAPTURE: clears done, tlast_err and beat_cnt, with the same timing as from IDLE.
- arm in CAPTURE or DRAIN is ignored.
- Read port:
  - rEn=1 -> rData<=ram[rAddr] on the next edge (latency 1).
  - rEn=0 -> rData holds its value.
  - Reads are allowed in all states; data is coherent only when done=1.
  - Read and write to the same address in one cycle returns the old word.
  - rAddr >= N_ELEMENTS cannot occur (power-of-two depth).
- Reset mid-capture: immediate return to IDLE with all outputs at reset values. A partial frame stays in RAM with done=0.
- beat_cnt reaches POINT_SIZE on completion, which is why it is NFFT+1 bits wide.

Decomposition:
- Shared package holds the state encoding constants (IDLE/CAPTURE/DRAIN/DONE) and the {IM,RE} field slice constants (RE_LSB=0, IM_LSB=32, WORD_W=32). These are the same slices used by the FFT input stage.
- One natural sub-module: fft_sample_ram, a simple dual-port RAM with a 64-bit single-beat write into two consecutive words and a 32-bit registered read. It is infer-friendly; the FSM stays in the top module.

Test Plan:
- Normal capture, NFFT=3: arm, then 8 back-to-back beats, data={i+100, i}, tlast on beat 7 -> done=1, tlast_err=0, beat_cnt=8. Reading addr 0..15 returns 0,100,1,101,...,7,107, each one cycle after rEn. s_tready=0 after the last beat.
- Backpressure/gaps: the same frame with s_tvalid low for 3 cycles between every beat -> RAM contents, done and beat_cnt identical to the normal case. The index does not advance on gap cycles.
- Early tlast: RAM preloaded with 0xDEAD by a prior frame; new frame with tlast on beat 4 -> done=1, tlast_err=1, beat_cnt=5. Words 10..15 still read the prior frame's values.
- Missing tlast: 8 beats with no tlast, then 3 extra beats with tlast on the third -> tlast_err=1; s_tready stays 1 through DRAIN; RAM holds the first 8 beats only; done=1 after the third extra beat.
- Reset mid-capture: resetn low after beat 3 -> the next cycle shows s_tready=0, capturing=0, done=0, tlast_err=0, beat_cnt=0. A fresh arm plus 8 beats completes normally.
- arm handling: arm pulsed during CAPTURE at beat 2 -> ignored, capture completes at beat 7 with beat_cnt=8. arm in DONE -> done and tlast_err clear and s_tready=1 on the next cycle.
